// File: rtl/fwft_fifo.sv
// ============================================================================
// Module      : fwft_fifo
// Description : Single-clock first-word-fall-through FIFO; the head word is
//               presented on dout combinationally whenever empty is low.
//               Optional sticky overflow/underflow flags with FIFO_ERR_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fwft_fifo #(
  parameter int FIFO_DATA_WIDTH   = 8,
  parameter int FIFO_BUFFER_SIZE  = 16,
  parameter int ALMOST_FULL_LEVEL = FIFO_BUFFER_SIZE - 2
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 wr_en,
  input  logic [FIFO_DATA_WIDTH-1:0]           din,
  output logic                                 full,
  output logic                                 almost_full,
  input  logic                                 rd_en,
  output logic [FIFO_DATA_WIDTH-1:0]           dout,
  output logic                                 empty,
  output logic [$clog2(FIFO_BUFFER_SIZE):0]    count
`ifdef FIFO_ERR_EN
  ,
  output logic                                 overflow,
  output logic                                 underflow
`endif
);

  localparam int AW = $clog2(FIFO_BUFFER_SIZE);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_LEVEL = PW'(ALMOST_FULL_LEVEL);

  logic [FIFO_DATA_WIDTH-1:0] mem [FIFO_BUFFER_SIZE];
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic                       wr_accept;
  logic                       rd_accept;

  // Status is a function of the registered pointers only.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count       = wr_ptr - rd_ptr;
  assign almost_full = (count >= AF_LEVEL);

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

`ifdef FIFO_ERR_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwft_fifo.sv
// Testbench for fwft_fifo: queue-based reference model with per-cycle compare
// plus directed literal checks.
`default_nettype none

module tb_fwft_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int AFL   = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock;
  logic          reset;
  logic          wr_en;
  logic [W-1:0]  din;
  logic          full;
  logic          almost_full;
  logic          rd_en;
  logic [W-1:0]  dout;
  logic          empty;
  logic [CW-1:0] count;
`ifdef FIFO_ERR_EN
  logic          overflow;
  logic          underflow;
`endif

  int tests = 0;
  int fails = 0;

  logic [W-1:0] q[$];

  fwft_fifo #(
    .FIFO_DATA_WIDTH   (W),
    .FIFO_BUFFER_SIZE  (DEPTH),
    .ALMOST_FULL_LEVEL (AFL)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .din         (din),
    .full        (full),
    .almost_full (almost_full),
    .rd_en       (rd_en),
    .dout        (dout),
    .empty       (empty),
    .count       (count)
`ifdef FIFO_ERR_EN
    ,
    .overflow    (overflow),
    .underflow   (underflow)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy as a queue, updated from the inputs seen at each edge.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      q.delete();
    end else begin
      automatic bit do_wr = wr_en && (q.size() < DEPTH);
      automatic bit do_rd = rd_en && (q.size() > 0);
      if (do_rd) void'(q.pop_front());
      if (do_wr) q.push_back(din);
    end
  end

  always @(negedge clock) begin
    automatic int n = q.size();
    chk("m_empty",  32'(empty),       32'(n == 0));
    chk("m_full",   32'(full),        32'(n == DEPTH));
    chk("m_count",  32'(count),       32'(n));
    chk("m_afull",  32'(almost_full), 32'(n >= AFL));
    chk("m_excl",   32'(full && empty), 32'd0);
    if (n > 0) chk("m_dout", 32'(dout), 32'(q[0]));
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    logic [W-1:0] wv [4];
    wv[0] = 8'h11; wv[1] = 8'h22; wv[2] = 8'h33; wv[3] = 8'h44;
    reset = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    repeat (3) tick();
    reset = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_empty", 32'(empty), 32'd1);
      chk("idle_full",  32'(full),  32'd0);
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_afull", 32'(almost_full), 32'd0);
    end

    // Fill to full
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = wv[i];
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_afull", 32'(almost_full), 32'(i >= 1));
      chk("fill_dout",  32'(dout), 32'h11);
      chk("fill_empty", 32'(empty), 32'd0);
    end
    chk("full_flag", 32'(full), 32'd1);
    din = 8'h55;
    tick();
    chk("drop_count", 32'(count), 32'd4);
    chk("drop_dout",  32'(dout), 32'h11);
`ifdef FIFO_ERR_EN
    chk("overflow", 32'(overflow), 32'd1);
`endif
    wr_en = 1'b0;

    // Drain with rd_en held high past empty
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) chk("drain_dout", 32'(dout), 32'(wv[i]));
      tick();
      if (i >= 3) begin
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_count", 32'(count), 32'd0);
      end
    end
`ifdef FIFO_ERR_EN
    chk("underflow", 32'(underflow), 32'd1);
`endif
    rd_en = 1'b0;

    // Preload two words, then streaming read+write at count=2
    wr_en = 1'b1;
    din = 8'h00; tick();
    din = 8'h01; tick();
    rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din = 8'(i + 2);
      chk("stream_dout", 32'(dout), 32'(i));
      tick();
      chk("stream_count", 32'(count), 32'd2);
    end
    rd_en = 1'b0;
    din = 8'h77;
    tick();
    chk("pre_rst_count", 32'(count), 32'd3);
    wr_en = 1'b0;

    // Asynchronous reset mid-operation
    reset = 1'b0;
    #1;
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_count", 32'(count), 32'd0);
    tick();
    reset = 1'b1;
    wr_en = 1'b1;
    din = 8'hA5;
    tick();
    chk("post_rst_dout",  32'(dout), 32'hA5);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_empty", 32'(empty), 32'd0);
    wr_en = 1'b0;

    // Random traffic against the queue model
    for (int i = 0; i < 2000; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      rd_en = 1'($urandom_range(0, 1));
      din   = 8'($urandom);
      tick();
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fwft_fifo.md
Name: fwft_fifo

Overview:
- Single-clock, first-word-fall-through FIFO that is the responder for the FIFO master ports on every pixel-stream stage in the edge_detect pipeline. Stages drive rd_en/wr_en and sample empty/full/dout.
- Stages read with rd_en and consume dout in the same cycle, so the head word must be valid on dout whenever empty is low, with no read latency.
- One instance sits between each pair of stages, e.g. grayscale -> fwft_fifo -> sobel -> fwft_fifo -> image writer.

Parameters:
- FIFO_DATA_WIDTH, 8, width of din/dout in bits.
- FIFO_BUFFER_SIZE, 16, depth in words; must be a power of two and at least 2.
- ALMOST_FULL_LEVEL, FIFO_BUFFER_SIZE-2, count at or above which almost_full asserts.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- wr_en  input  1  write request from the upstream stage.
- din  input  FIFO_DATA_WIDTH  write data.
- full  output  1  FIFO holds FIFO_BUFFER_SIZE words.
- almost_full  output  1  count >= ALMOST_FULL_LEVEL.
- rd_en  input  1  read request (pop) from the downstream stage.
- dout  output  FIFO_DATA_WIDTH  head word; valid whenever empty=0.
- empty  output  1  FIFO holds 0 words.
- count  output  $clog2(FIFO_BUFFER_SIZE)+1  current occupancy.

Behaviour:
- Storage: array of FIFO_BUFFER_SIZE words; wr_ptr and rd_ptr are $clog2(FIFO_BUFFER_SIZE)+1 bits wide, with the MSB as wrap bit.
- Status: full, empty, almost_full and count derive from registered pointers only, with no combinational path from wr_en/rd_en. full is true when addresses are equal and wrap bits differ; empty when pointers are equal; count = wr_ptr - rd_ptr, modulo 2^(ptr width).
- Reset (reset=0, async): both pointers = 0. Outputs read count=0, empty=1, full=0, almost_full=0. Storage contents are not cleared. dout is don't-care while empty; the bench must not check it.
- Accepted write: wr_en && !full at the rising edge. mem[wr_ptr] <= din, wr_ptr++.
- Accepted read: rd_en && !empty at the rising edge. rd_ptr++.
- dout = mem[rd_ptr], an asynchronous read of the head.
- Write latency: a word written at edge N sits on dout and empty=0 immediately after edge N, provided the FIFO was empty before the edge.
- Write while full: dropped, even if rd_en is high in the same cycle. Pointers are unchanged on the write side.
- Read while empty: ignored. rd_ptr is unchanged and dout is undefined.
- Simultaneous accepted read and write: count unchanged. When count=1, dout switches to the new word after the edge.
- Wrap-around: pointer addresses wrap from FIFO_BUFFER_SIZE-1 to 0 and the wrap bit toggles. There is no bubble and no lost word across the wrap.
- Reset mid-operation: all words are discarded immediately (async). The first write after reset deassertion lands at address 0.
- No state machine beyond the pointer pair. A stage may hold rd_en high continuously; the FIFO gates it by empty internally.

Optional Feature:
- FIFO_ERR_EN defined:
  - Adds outputs overflow (1) and underflow (1).
  - overflow sets on any edge where wr_en && full; underflow sets on any edge where rd_en && empty.
  - Both flags are sticky and cleared only by reset (reset value 0). They have no effect on data or pointers.
- FIFO_ERR_EN undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then idle, FIFO_BUFFER_SIZE=4 -> empty=1, full=0, count=0, almost_full=0 held for 10 cycles.
- Write 0x11,0x22,0x33,0x44 on consecutive cycles (size 4, ALMOST_FULL_LEVEL=2):
  - After the first edge: dout=0x11, empty=0.
  - almost_full=1 from count=2.
  - After the fourth edge: full=1, count=4.
  - A further write of 0x55 is dropped, and with FIFO_ERR_EN overflow=1.
- From full, hold rd_en=1 for 5 cycles -> dout sequence 0x11,0x22,0x33,0x44. empty=1 after the fourth edge; count reaches 0 and does not underflow. With FIFO_ERR_EN, underflow=1 after the fifth edge.
- Continuous simultaneous read/write at count=2 for 20 cycles, data 0x00..0x13 -> count stays 2 throughout, output order is exactly the input order, and pointers wrap 5 times without loss.
- Assert reset low for 1 cycle at count=3 -> empty=1 and count=0 asynchronously. The next write 0xA5 appears on dout one edge later.
- Random wr_en/rd_en at 50% for 2000 cycles against a queue scoreboard -> zero mismatches. count always equals the scoreboard size, and full/empty never assert together.
